rv32i_trace_tx: RTL and testbench

Retirement-trace transmitter for the single-cycle RV32I core. It captures one retire record per accepted instruction from the core's debug signals (PC, instruction, writeback, store, control-flow flags) and serialises it into a framed 32-bit word stream with valid/ready flow control. The stream is the producer side of the instruction-trace link consumed by log/monitor logic. The block sits beside `rv32i_top`, fed from its debug outputs, and drives an off-core trace sink.

---
 rtl/rv32i_trace_pkg.sv | 52 +++++
 rtl/rv32i_trace_tx_if.sv | 39 +++
 rtl/trace_fifo.sv | 48 ++++
 rtl/rv32i_trace_tx.sv | 135 +++++++++++++
 tb/tb_rv32i_trace_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_trace_pkg.sv
// Shared constants, header layout and FSM encoding for the RV32I retirement-trace transmitter.
package rv32i_trace_pkg;

    localparam int TRACE_W = 32;

    localparam logic [3:0] HDR_SYNC     = 4'hA;
    localparam int         HDR_SYNC_LSB = 28;
    localparam int         HDR_JMP_BIT  = 27;
    localparam int         HDR_RW_BIT   = 26;
    localparam int         HDR_MW_BIT   = 25;
    localparam int         HDR_LOST_BIT = 24;
    localparam int         HDR_RD_LSB   = 19;
    localparam int         HDR_SEQ_LSB  = 11;
    localparam int         HDR_DROP_LSB = 3;
    localparam int         HDR_CNT_LSB  = 0;

    localparam int MAX_PKT_LEN = 5;
    localparam int CNT_W       = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PC    = 3'd2,
        ST_WB    = 3'd3,
        ST_MADDR = 3'd4,
        ST_MDATA = 3'd5
    } trace_state_e;

    function automatic logic [TRACE_W-1:0] build_hdr(
        input logic             jmp,
        input logic             rw,
        input logic             mw,
        input logic [4:0]       rd,
        input logic [7:0]       seq,
        input logic [7:0]       drop,
        input logic [CNT_W-1:0] cnt
    );
        logic [TRACE_W-1:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 4]     = HDR_SYNC;
        h[HDR_JMP_BIT]           = jmp;
        h[HDR_RW_BIT]            = rw;
        h[HDR_MW_BIT]            = mw;
        h[HDR_LOST_BIT]          = (drop != 8'd0);
        h[HDR_RD_LSB +: 5]       = rd;
        h[HDR_SEQ_LSB +: 8]      = seq;
        h[HDR_DROP_LSB +: 8]     = drop;
        h[HDR_CNT_LSB +: CNT_W]  = cnt;
        return h;
    endfunction

endpackage

// File: rtl/rv32i_trace_tx_if.sv
// Retire-record input and trace-stream output bundle of the trace transmitter.
interface rv32i_trace_tx_if;
    import rv32i_trace_pkg::*;

    logic               i_ret_valid;
    logic               o_ret_ready;
    logic [TRACE_W-1:0] i_pc;
    logic [TRACE_W-1:0] i_instr;
    logic               i_reg_write;
    logic [4:0]         i_rd;
    logic [TRACE_W-1:0] i_wb_data;
    logic               i_mem_write;
    logic [TRACE_W-1:0] i_mem_addr;
    logic [TRACE_W-1:0] i_mem_wdata;
    logic               i_branch_taken;
    logic               i_jal;
    logic               i_jalr;
    logic [TRACE_W-1:0] o_tdata;
    logic               o_tvalid;
    logic               o_tlast;
    logic               i_tready;
    logic [7:0]         o_drop_cnt;

    // master is the transmitter; slave is the core/sink side driving it.
    modport master (
        input  i_ret_valid, i_pc, i_instr, i_reg_write, i_rd, i_wb_data,
               i_mem_write, i_mem_addr, i_mem_wdata, i_branch_taken, i_jal, i_jalr,
               i_tready,
        output o_ret_ready, o_tdata, o_tvalid, o_tlast, o_drop_cnt
    );

    modport slave (
        output i_ret_valid, i_pc, i_instr, i_reg_write, i_rd, i_wb_data,
               i_mem_write, i_mem_addr, i_mem_wdata, i_branch_taken, i_jal, i_jalr,
               i_tready,
        input  o_ret_ready, o_tdata, o_tvalid, o_tlast, o_drop_cnt
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; head entry is read straight from the storage registers.
module trace_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take a word.
    assign push_ok = ~full | do_pop;
    assign do_push = push & push_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/rv32i_trace_tx.sv
// Captures one retire record per accepted instruction and serialises it as a framed 2..5 word packet.
module rv32i_trace_tx
    import rv32i_trace_pkg::*;
#(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    rv32i_trace_tx_if.master trc
);
    trace_state_e     state_reg;
    trace_state_e     state_next;
    logic [7:0]       seq_reg;
    logic [7:0]       drop_reg;
    logic [N-1:0]     hdr_reg;
    logic [N-1:0]     pc_reg;
    logic [N-1:0]     wb_reg;
    logic [N-1:0]     maddr_reg;
    logic [N-1:0]     mdata_reg;
    logic             rw_reg;
    logic             mw_reg;

    logic             accept;
    logic             drop;
    logic             push;
    logic             push_ok;
    logic             last_state;
    logic [N-1:0]     push_word;
    logic [N:0]       head_data;
    logic             fifo_empty;
    logic             ret_ready;
    logic             in_jmp;
    logic             in_rw;
    logic             in_mw;
    logic [CNT_W-1:0] in_cnt;
    logic             unused_instr;

    assign unused_instr = ^trc.i_instr;

    assign in_jmp = trc.i_branch_taken | trc.i_jal | trc.i_jalr;
    assign in_rw  = trc.i_reg_write & (trc.i_rd != 5'd0);
    assign in_mw  = trc.i_mem_write;
    assign in_cnt = CNT_W'(2) + CNT_W'(in_rw) + (in_mw ? CNT_W'(2) : CNT_W'(0));

    always_comb begin
        push_word  = '0;
        last_state = 1'b0;
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_HDR: begin
                push_word  = hdr_reg;
                state_next = ST_PC;
            end
            ST_PC: begin
                push_word  = pc_reg;
                last_state = ~rw_reg & ~mw_reg;
                state_next = rw_reg ? ST_WB : (mw_reg ? ST_MADDR : ST_IDLE);
            end
            ST_WB: begin
                push_word  = wb_reg;
                last_state = ~mw_reg;
                state_next = mw_reg ? ST_MADDR : ST_IDLE;
            end
            ST_MADDR: begin
                push_word  = maddr_reg;
                state_next = ST_MDATA;
            end
            ST_MDATA: begin
                push_word  = mdata_reg;
                last_state = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign push      = (state_reg != ST_IDLE) & push_ok;
    // Ready in the last-word cycle lets the next packet start with no idle gap.
    assign ret_ready = (state_reg == ST_IDLE) | (last_state & push);
    assign accept    = trc.i_ret_valid & ret_ready;
    assign drop      = trc.i_ret_valid & ~ret_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            seq_reg   <= 8'd0;
            drop_reg  <= 8'd0;
        end else begin
            if (accept)    state_reg <= ST_HDR;
            else if (push) state_reg <= state_next;

            if (accept) begin
                seq_reg  <= seq_reg + 8'd1;
                drop_reg <= 8'd0;
            end else if (drop && drop_reg != 8'hFF) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hdr_reg   <= build_hdr(in_jmp, in_rw, in_mw, trc.i_rd, seq_reg, drop_reg, in_cnt);
            pc_reg    <= trc.i_pc;
            wb_reg    <= trc.i_wb_data;
            maddr_reg <= trc.i_mem_addr;
            mdata_reg <= trc.i_mem_wdata;
            rw_reg    <= in_rw;
            mw_reg    <= in_mw;
        end
    end

    trace_fifo #(
        .WIDTH (N + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({last_state, push_word}),
        .push_ok   (push_ok),
        .pop       (trc.i_tready),
        .head_data (head_data),
        .empty     (fifo_empty)
    );

    assign trc.o_ret_ready = ret_ready;
    assign trc.o_tvalid    = ~fifo_empty;
    assign trc.o_tdata     = head_data[N-1:0];
    assign trc.o_tlast     = head_data[N];
    assign trc.o_drop_cnt  = drop_reg;

endmodule

// File: tb/tb_rv32i_trace_tx.sv
// Directed bench for rv32i_trace_tx: packet framing, flow control, drop counting, seq wrap, reset abort.
`timescale 1ns/1ps
module tb_rv32i_trace_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_trace_tx_if tif();

    rv32i_trace_tx #(.N(32), .FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .trc (tif)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    always @(negedge clk) begin
        if (rst && tif.o_tvalid && tif.i_tready)
            got_q.push_back({tif.o_tlast, tif.o_tdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time=%0t expected=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic drive_ret(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                             input logic [31:0] wb, input logic mw, input logic [31:0] ma,
                             input logic [31:0] md, input logic jal);
        tif.i_pc           = pc;
        tif.i_instr        = 32'h0000_0013;
        tif.i_reg_write    = rw;
        tif.i_rd           = rd;
        tif.i_wb_data      = wb;
        tif.i_mem_write    = mw;
        tif.i_mem_addr     = ma;
        tif.i_mem_wdata    = md;
        tif.i_branch_taken = 1'b0;
        tif.i_jal          = jal;
        tif.i_jalr         = 1'b0;
        tif.i_ret_valid    = 1'b1;
    endtask

    task automatic send(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                        input logic [31:0] wb, input logic mw, input logic [31:0] ma,
                        input logic [31:0] md, input logic jal);
        int t;
        drive_ret(pc, rw, rd, wb, mw, ma, md, jal);
        t = 0;
        while (!tif.o_ret_ready && t < 100) begin
            step();
            t++;
        end
        if (!tif.o_ret_ready) check("send_ready", {63'd0, tif.o_ret_ready}, 64'd1);
        step();
        tif.i_ret_valid = 1'b0;
    endtask

    task automatic ew(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] acc_mask;
        tif.i_ret_valid    = 1'b0;
        tif.i_pc           = '0;
        tif.i_instr        = '0;
        tif.i_reg_write    = 1'b0;
        tif.i_rd           = '0;
        tif.i_wb_data      = '0;
        tif.i_mem_write    = 1'b0;
        tif.i_mem_addr     = '0;
        tif.i_mem_wdata    = '0;
        tif.i_branch_taken = 1'b0;
        tif.i_jal          = 1'b0;
        tif.i_jalr         = 1'b0;
        tif.i_tready       = 1'b0;

        rst = 1'b0;
        idle_cycles(3);
        check("rst_ready",  tif.o_ret_ready, 1);
        check("rst_tvalid", tif.o_tvalid, 0);
        check("rst_tdata",  tif.o_tdata, 0);
        check("rst_tlast",  tif.o_tlast, 0);
        check("rst_drop",   tif.o_drop_cnt, 0);
        rst = 1'b1;
        tif.i_tready = 1'b1;
        step();

        // ADD x3, seq 0
        send(32'h10, 1'b1, 5'd3, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycles(10);
        ew(32'hA418_0003, 1'b0); ew(32'h10, 1'b0); ew(32'h5, 1'b1);
        cmp_stream("add");
        check("add_drop", tif.o_drop_cnt, 0);

        // SW, seq 1
        send(32'hD0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
        idle_cycles(10);
        ew(32'hA200_0804, 1'b0); ew(32'hD0, 1'b0); ew(32'h40, 1'b0); ew(32'hDEAD_BEEF, 1'b1);
        cmp_stream("sw");

        // JAL x0, seq 2
        send(32'h100, 1'b1, 5'd0, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(10);
        ew(32'hA800_1002, 1'b0); ew(32'h100, 1'b1);
        cmp_stream("jal");

        // back-to-back JAL, valid held 8 cycles: accepts every other cycle, seq 3..6
        acc_mask = 8'h00;
        drive_ret(32'h200, 1'b1, 5'd0, 32'h204, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (tif.o_ret_ready) acc_mask[i] = 1'b1;
            step();
        end
        tif.i_ret_valid = 1'b0;
        idle_cycles(10);
        check("b2b_accept_mask", acc_mask, 8'h55);
        check("b2b_drop", tif.o_drop_cnt, 1);
        ew(32'hA800_1802, 1'b0); ew(32'h200, 1'b1);
        ew(32'hA900_200A, 1'b0); ew(32'h200, 1'b1);
        ew(32'hA900_280A, 1'b0); ew(32'h200, 1'b1);
        ew(32'hA900_300A, 1'b0); ew(32'h200, 1'b1);
        cmp_stream("b2b");

        // sink stalled: FIFO fills with 4 packets, 5th waits in HDR, drops accumulate
        tif.i_tready = 1'b0;
        drive_ret(32'h300, 1'b1, 5'd0, 32'h304, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(20);
        check("stall_drop",   tif.o_drop_cnt, 11);
        check("stall_ready",  tif.o_ret_ready, 0);
        check("stall_tvalid", tif.o_tvalid, 1);
        check("stall_head",   tif.o_tdata, 32'hA900_380A);
        tif.i_ret_valid = 1'b0;
        idle_cycles(3);
        check("stall_hold",   tif.o_tdata, 32'hA900_380A);
        tif.i_tready = 1'b1;
        idle_cycles(20);
        check("stall_drop_kept", tif.o_drop_cnt, 11);
        ew(32'hA900_380A, 1'b0); ew(32'h300, 1'b1);
        ew(32'hA900_400A, 1'b0); ew(32'h300, 1'b1);
        ew(32'hA900_480A, 1'b0); ew(32'h300, 1'b1);
        ew(32'hA900_500A, 1'b0); ew(32'h300, 1'b1);
        ew(32'hA900_580A, 1'b0); ew(32'h300, 1'b1);
        cmp_stream("stall");

        send(32'h310, 1'b1, 5'd0, 32'h314, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(10);
        ew(32'hA900_605A, 1'b0); ew(32'h310, 1'b1);
        cmp_stream("lost");
        check("lost_drop_clr", tif.o_drop_cnt, 0);

        // long stall: drop counter saturates at 255
        tif.i_tready = 1'b0;
        drive_ret(32'h400, 1'b1, 5'd0, 32'h404, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(300);
        tif.i_ret_valid = 1'b0;
        check("sat_drop", tif.o_drop_cnt, 255);
        tif.i_tready = 1'b1;
        idle_cycles(20);
        check("sat_len", got_q.size(), 10);
        got_q.delete();
        send(32'h410, 1'b1, 5'd0, 32'h414, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(10);
        ew(32'hA900_97FA, 1'b0); ew(32'h410, 1'b1);
        cmp_stream("sat");
        check("sat_drop_clr", tif.o_drop_cnt, 0);

        // seq 19..255 back-to-back, then wrap to 0
        drive_ret(32'h500, 1'b1, 5'd0, 32'h504, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(474);
        tif.i_ret_valid = 1'b0;
        idle_cycles(10);
        check("wrap_len", got_q.size(), 474);
        if (got_q.size() == 474) begin
            check("wrap_first_hdr", got_q[0], {1'b0, 32'hA800_9802});
            check("wrap_seq255_hdr", got_q[472], {1'b0, 32'hA907_F80A});
            check("wrap_seq255_pc", got_q[473], {1'b1, 32'h500});
        end
        got_q.delete();
        send(32'h510, 1'b1, 5'd0, 32'h514, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(10);
        ew(32'hA900_000A, 1'b0); ew(32'h510, 1'b1);
        cmp_stream("wrap0");

        // reset in the middle of a stalled store packet
        tif.i_tready = 1'b0;
        send(32'h600, 1'b0, 5'd0, 32'h0, 1'b1, 32'h44, 32'h55, 1'b0);
        idle_cycles(2);
        check("mid_tvalid", tif.o_tvalid, 1);
        rst = 1'b0;
        step();
        check("mrst_ready",  tif.o_ret_ready, 1);
        check("mrst_tvalid", tif.o_tvalid, 0);
        check("mrst_tdata",  tif.o_tdata, 0);
        check("mrst_tlast",  tif.o_tlast, 0);
        check("mrst_drop",   tif.o_drop_cnt, 0);
        rst = 1'b1;
        tif.i_tready = 1'b1;
        idle_cycles(5);
        check("mrst_no_words", got_q.size(), 0);
        got_q.delete();
        send(32'h10, 1'b1, 5'd3, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycles(10);
        ew(32'hA418_0003, 1'b0); ew(32'h10, 1'b0); ew(32'h5, 1'b1);
        cmp_stream("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
